burst_rr_scheduler: RTL and testbench
=====================================

# burst_rr_scheduler

Round-robin scheduler that shares one multi-beat resource, such as a memory port or a serial engine, among N requesters. It extends plain per-cycle round-robin arbitration with burst ownership. The winner keeps a registered one-hot grant until its requested number of beats has been consumed. Only then does the rotating priority pointer move past it. The block sits between the requester bank and the shared resource's beat handshake.

## Interface
- N, 5, number of requesters (2..16)
- LENW, 4, width of each burst-length field; burst length = len+1 beats (1..2^LENW)
- TO_CYCLES, 16, stall limit in cycles; used only when BURST_RR_TIMEOUT_EN is defined

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low; the codebase reset port carrying the active-low suffix
- req  in  N  per-requester request level
- req_len  in  N*LENW  packed burst lengths; requester i uses bits [i*LENW +: LENW]
- beat  in  1  resource consumed one beat of the current burst this cycle
- grant  out  N  registered one-hot owner; all-zero when idle
- grant_id  out  $clog2(N)  binary index of owner; 0 when idle
- beats_left  out  LENW  beats remaining after the current one; 0 on the last beat
- last  out  1  combinational, (grant!=0) && beats_left==0
- timeout  out  1  one-cycle pulse marking an aborted burst; constant 0 when the macro is undefined

## Operation
- Pointer: one-hot, reset value 1 (requester 0 has highest priority).
- Selection: the first asserted req at or above the pointer position, wrapping modulo N.
- States are IDLE and BUSY.
- IDLE:
  - If req!=0, the selected requester is registered into grant and grant_id.
  - beats_left loads that requester's req_len.
  - State goes to BUSY.
- BUSY:
  - beat with beats_left>0 decrements beats_left.
  - beat with beats_left==0 ends the burst. The pointer becomes the owner's one-hot rotated left by 1, wrapping N-1 to 0.
- Back-to-back arbitration: on the ending beat, selection runs in the same cycle, using the already-advanced pointer and the current req.
  - If a requester is selected, the new grant takes effect next cycle with no idle bubble.
  - If none is selected, the next state is IDLE with grant=0.
  - The finishing owner's own req is eligible but has lowest priority.
- req is sampled only at selection. Deasserting req mid-burst neither shortens nor aborts the burst. Asserting req mid-burst has no effect until the burst ends.
- beat while grant==0 is ignored.
- The pointer changes only when a burst ends or on a timeout abort.
- grant is always one-hot or zero, and is never taken from an owner before its burst ends or it times out.

## Timing
- Reset state: grant=0, grant_id=0, beats_left=0, last=0, timeout=0, pointer=1, state IDLE. The pointer and state take these values immediately on rst_n low, independent of clk.
- Grant latency: 1 cycle. req is sampled at edge k and grant is visible after edge k.
- The first beat may be presented in the cycle grant first becomes visible.
- A burst of len+1 beats with beat held high occupies exactly len+1 grant cycles.
- Back-to-back bursts: the next owner's grant appears in the cycle after the last beat.
- Reset mid-burst aborts immediately: no timeout pulse, pointer returns to 1.

## Configuration
- BURST_RR_TIMEOUT_EN defined:
  - A stall counter runs in BUSY. It clears on beat and on every new grant.
  - If it reaches TO_CYCLES-1 without a beat, the burst is aborted: timeout pulses for 1 cycle, the pointer advances past the owner, and arbitration proceeds exactly as for an ending beat.
  - Exact rule: with no beat for TO_CYCLES consecutive grant cycles, timeout and the abort coincide with the TO_CYCLES-th such cycle.
- BURST_RR_TIMEOUT_EN undefined:
  - No counter is built and timeout is tied 0.
  - An owner without beats holds grant indefinitely.

## Test plan
- Reset, then req=5'b00100 with len=2 and beat held high -> grant=00100 one cycle later for exactly 3 cycles; last in the 3rd cycle; grant=0 afterwards.
- req=5'b11111 held, all len=0, beat high -> grants rotate 00001, 00010, 00100, 01000, 10000, 00001, with no idle cycles.
- Owner 1 with len=3; req[1] dropped after grant, beat toggling 1/0 -> grant stays on 1 until 4 beats are counted; beats_left steps 3, 2, 1, 0.
- Owner 3 finishing while req=5'b01001 -> next grant=00001, not 01000.
- rst_n pulsed low mid-burst (beats_left=2) -> all outputs 0 immediately; after release, req=5'b10010 grants 00010 (pointer back to 1).
- With BURST_RR_TIMEOUT_EN and TO_CYCLES=4: owner 2 with no beats -> timeout pulse in the 4th grant cycle; pending req[0] is granted the next cycle.

Source files
------------

// File: rtl/burst_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : burst_rr_scheduler
// Purpose  : Round-robin scheduler with burst ownership for one shared
//            multi-beat resource. The winner holds a registered one-hot grant
//            until its len+1 beats are consumed. Only then does the rotating
//            priority pointer move past it. The next owner is picked in the
//            same cycle as the ending beat, so back-to-back bursts have no
//            idle bubble.
// Options  : BURST_RR_TIMEOUT_EN - when defined, a stall counter aborts a
//            burst after TO_CYCLES consecutive grant cycles without a beat.
//            When undefined, no counter is built and timeout is tied to 0.
// Ports    : clk        - clock, all state on rising edge
//            rst_n      - asynchronous active-low reset
//            req        - [N]        per-requester request level
//            req_len    - [N*LENW]   burst length minus one, field i at
//                                    [i*LENW +: LENW]
//            beat       - resource consumed one beat this cycle
//            grant      - [N]        registered one-hot owner, 0 when idle
//            grant_id   - [log2 N]   binary owner index, 0 when idle
//            beats_left - [LENW]     beats remaining after the current one
//            last       - owner present and on its final beat
//            timeout    - one-cycle pulse marking an aborted burst
// Revision : 1.0 - initial release
// ============================================================================
module burst_rr_scheduler #(
  parameter int N         = 5,
  parameter int LENW      = 4,
  parameter int TO_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           req,
  input  logic [N*LENW-1:0]      req_len,
  input  logic                   beat,
  output logic [N-1:0]           grant,
  output logic [$clog2(N)-1:0]   grant_id,
  output logic [LENW-1:0]        beats_left,
  output logic                   last,
  output logic                   timeout
);

  localparam int IDW = $clog2(N);
  localparam logic [N-1:0] c_one = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      grant_q, grant_d;
  logic [IDW-1:0]    grant_id_q, grant_id_d;
  logic [LENW-1:0]   beats_left_q, beats_left_d;
  logic [N-1:0]      ptr_q, ptr_d;
  logic [N-1:0]      w_sel;
  logic              w_timeout;

  // --------------------------------------------------------------------------
  // First asserted request at or above the one-hot pointer, wrapping.
  // Requests at/above the pointer are isolated with ~(ptr-1); if none exist
  // the search wraps to the lowest asserted request. x & -x keeps the lowest
  // set bit.
  // --------------------------------------------------------------------------
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] ptr,
                                           input logic [N-1:0] r);
    logic [N-1:0] hi;
    logic [N-1:0] src;
    hi  = r & ~(ptr - c_one);
    src = (hi != '0) ? hi : r;
    return src & (~src + c_one);
  endfunction

  function automatic logic [IDW-1:0] oh2bin(input logic [N-1:0] oh);
    logic [IDW-1:0] b;
    b = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) b = b | IDW'(i);
    end
    return b;
  endfunction

  function automatic logic [LENW-1:0] len_of(input logic [N-1:0]      oh,
                                             input logic [N*LENW-1:0] lens);
    logic [LENW-1:0] l;
    l = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) l = l | lens[i*LENW +: LENW];
    end
    return l;
  endfunction

  // --------------------------------------------------------------------------
  // Stall timeout
  // --------------------------------------------------------------------------
`ifdef BURST_RR_TIMEOUT_EN
  localparam int STALLW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

  logic [STALLW-1:0] stall_q, stall_d;

  // Fires in the TO_CYCLES-th consecutive beat-less grant cycle: the counter
  // is 0 in the first grant cycle, so it reads TO_CYCLES-1 in that cycle.
  assign w_timeout = (state_q == S_BUSY) && !beat &&
                     (stall_q == STALLW'(TO_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    grant_id_d   = grant_id_q;
    beats_left_d = beats_left_q;
    ptr_d        = ptr_q;
    w_sel        = '0;

    case (state_q)
      S_IDLE: begin
        w_sel = rr_pick(ptr_q, req);
      end
      S_BUSY: begin
        if (beat && (beats_left_q != '0)) begin
          beats_left_d = beats_left_q - LENW'(1);
        end
        if ((beat && (beats_left_q == '0)) || w_timeout) begin
          // Burst over: move the pointer past the owner and re-arbitrate
          // right away against the advanced pointer, so the finishing
          // owner competes at lowest priority.
          ptr_d        = {grant_q[N-2:0], grant_q[N-1]};
          w_sel        = rr_pick(ptr_d, req);
          state_d      = S_IDLE;
          grant_d      = '0;
          grant_id_d   = '0;
          beats_left_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (w_sel != '0) begin
      state_d      = S_BUSY;
      grant_d      = w_sel;
      grant_id_d   = oh2bin(w_sel);
      beats_left_d = len_of(w_sel, req_len);
    end
  end

`ifdef BURST_RR_TIMEOUT_EN
  always_comb begin
    stall_d = stall_q;
    if (state_q == S_BUSY) stall_d = stall_q + STALLW'(1);
    if (beat || (w_sel != '0)) stall_d = '0;
  end
`endif

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      grant_id_q   <= '0;
      beats_left_q <= '0;
      ptr_q        <= c_one;
`ifdef BURST_RR_TIMEOUT_EN
      stall_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grant_id_q   <= grant_id_d;
      beats_left_q <= beats_left_d;
      ptr_q        <= ptr_d;
`ifdef BURST_RR_TIMEOUT_EN
      stall_q      <= stall_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign grant      = grant_q;
  assign grant_id   = grant_id_q;
  assign beats_left = beats_left_q;
  assign last       = (grant_q != '0) && (beats_left_q == '0);
  assign timeout    = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_burst_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_burst_rr_scheduler
// Purpose  : Self-checking bench for burst_rr_scheduler (N=5, LENW=4,
//            TO_CYCLES=4). A vector table drives one cycle per record and
//            checks the registered outputs after the edge; hand-written
//            sequences cover asynchronous reset mid-burst and stall handling.
// Revision : 1.0 - initial release
// ============================================================================
module tb_burst_rr_scheduler;

  localparam int N    = 5;
  localparam int LENW = 4;
  localparam int TO   = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N-1:0]         req = '0;
  logic [N*LENW-1:0]    req_len = '0;
  logic                 beat = 1'b0;
  logic [N-1:0]         grant;
  logic [2:0]           grant_id;
  logic [LENW-1:0]      beats_left;
  logic                 last;
  logic                 timeout;

  burst_rr_scheduler #(
    .N         (N),
    .LENW      (LENW),
    .TO_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_len    (req_len),
    .beat       (beat),
    .grant      (grant),
    .grant_id   (grant_id),
    .beats_left (beats_left),
    .last       (last),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [N-1:0] g,
                         input logic [2:0] id, input logic [LENW-1:0] bl,
                         input logic lst, input logic to);
    chk({tag, ".grant"},      32'(grant),      32'(g));
    chk({tag, ".grant_id"},   32'(grant_id),   32'(id));
    chk({tag, ".beats_left"}, 32'(beats_left), 32'(bl));
    chk({tag, ".last"},       32'(last),       32'(lst));
    chk({tag, ".timeout"},    32'(timeout),    32'(to));
  endtask

  typedef struct {
    logic              rst;
    logic [N-1:0]      req;
    logic [N*LENW-1:0] len;
    logic              beat;
    logic [N-1:0]      g;
    logic [2:0]        id;
    logic [LENW-1:0]   bl;
    logic              lst;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic rst, input logic [N-1:0] r,
                     input logic [N*LENW-1:0] l, input logic b,
                     input logic [N-1:0] g, input logic [2:0] id,
                     input logic [LENW-1:0] bl, input logic lst);
    vec_t v;
    v.rst = rst; v.req = r; v.len = l; v.beat = b;
    v.g = g; v.id = id; v.bl = bl; v.lst = lst;
    vt.push_back(v);
  endtask

  initial begin
    // Single burst: owner 2, len 2 -> three grant cycles, last on third
    add(0, 5'b00100, 20'h00200, 1, 5'b00100, 2, 2, 0);
    add(0, 5'b00000, 20'h00000, 1, 5'b00100, 2, 1, 0);
    add(0, 5'b00000, 20'h00000, 1, 5'b00100, 2, 0, 1);
    add(0, 5'b00000, 20'h00000, 1, 5'b00000, 0, 0, 0);
    // Reset so rotation starts from requester 0
    add(1, 5'b00000, 20'h00000, 0, 5'b00000, 0, 0, 0);
    // All requesting, single-beat bursts: full rotation with no bubble
    add(0, 5'b11111, 20'h00000, 1, 5'b00001, 0, 0, 1);
    add(0, 5'b11111, 20'h00000, 1, 5'b00010, 1, 0, 1);
    add(0, 5'b11111, 20'h00000, 1, 5'b00100, 2, 0, 1);
    add(0, 5'b11111, 20'h00000, 1, 5'b01000, 3, 0, 1);
    add(0, 5'b11111, 20'h00000, 1, 5'b10000, 4, 0, 1);
    add(0, 5'b11111, 20'h00000, 1, 5'b00001, 0, 0, 1);
    add(0, 5'b00000, 20'h00000, 1, 5'b00000, 0, 0, 0);
    // Owner 1, len 3, req dropped, beat toggling
    add(0, 5'b00010, 20'h00030, 0, 5'b00010, 1, 3, 0);
    add(0, 5'b00000, 20'h00000, 1, 5'b00010, 1, 2, 0);
    add(0, 5'b00000, 20'h00000, 0, 5'b00010, 1, 2, 0);
    add(0, 5'b00000, 20'h00000, 1, 5'b00010, 1, 1, 0);
    add(0, 5'b00000, 20'h00000, 0, 5'b00010, 1, 1, 0);
    add(0, 5'b00000, 20'h00000, 1, 5'b00010, 1, 0, 1);
    add(0, 5'b00000, 20'h00000, 0, 5'b00010, 1, 0, 1);
    add(0, 5'b00000, 20'h00000, 1, 5'b00000, 0, 0, 0);
    // Owner 3 finishing with req=01001: requester 0 wins, 3 is lowest
    add(0, 5'b01000, 20'h00000, 0, 5'b01000, 3, 0, 1);
    add(0, 5'b01001, 20'h00000, 1, 5'b00001, 0, 0, 1);
    add(0, 5'b00000, 20'h00000, 1, 5'b00000, 0, 0, 0);
    // Owner 3 then owner 4 back-to-back; pointer ends at requester 4
    add(0, 5'b01000, 20'h00000, 0, 5'b01000, 3, 0, 1);
    add(0, 5'b10000, 20'h20000, 1, 5'b10000, 4, 2, 0);

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 5'b00000, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      rst_n   = !vt[i].rst;
      req     = vt[i].req;
      req_len = vt[i].len;
      beat    = vt[i].beat;
      @(posedge clk);
      #1;
      chk_all($sformatf("v%0d", i), vt[i].g, vt[i].id, vt[i].bl,
              vt[i].lst, 1'b0);
    end

    // Asynchronous reset mid-burst (owner 4, beats_left=2)
    @(negedge clk);
    beat  = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 5'b00000, 0, 0, 0, 0);
    @(negedge clk);
    rst_n   = 1'b1;
    req     = 5'b10010;
    req_len = '0;
    @(posedge clk);
    #1;
    chk_all("post_rst", 5'b00010, 1, 0, 1, 0);
    @(negedge clk);
    req  = '0;
    beat = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_rst_end", 5'b00000, 0, 0, 0, 0);

    // Stalled owner 2 (len 3) with requester 0 pending
    @(negedge clk);
    beat  = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    req     = 5'b00100;
    req_len = 20'h00300;
    @(posedge clk);
    #1;
    chk_all("stall_c1", 5'b00100, 2, 3, 0, 0);
    @(negedge clk);
    req = 5'b00001;
`ifdef BURST_RR_TIMEOUT_EN
    for (int c = 2; c <= TO; c++) begin
      @(posedge clk);
      #1;
      chk_all($sformatf("stall_c%0d", c), 5'b00100, 2, 3, 0, (c == TO));
    end
    @(posedge clk);
    #1;
    chk_all("after_timeout", 5'b00001, 0, 0, 1, 0);
`else
    for (int c = 2; c <= 21; c++) begin
      @(posedge clk);
      #1;
      chk_all($sformatf("hold_c%0d", c), 5'b00100, 2, 3, 0, 0);
    end
    @(negedge clk);
    beat = 1'b1;
    for (int k = 2; k >= 0; k--) begin
      @(posedge clk);
      #1;
      chk_all($sformatf("drain_bl%0d", k), 5'b00100, 2, LENW'(k),
              (k == 0), 0);
    end
    @(posedge clk);
    #1;
    chk_all("after_drain", 5'b00001, 0, 0, 1, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
